// File: rtl/gg_lattice_packer.sv
// gg_lattice_packer: packs right-aligned variable-length codes into an MSB-first stream of WID-bit windows plus PAD look-ahead bits and per-bit nc tags.
// Latency: a code accepted on edge k shows up in the window outputs from k+1; all outputs decode combinationally from the registered buffer.
// Backpressure: in_ready drops while draining or when a full IN_W code might not fit; window outputs hold while out_valid && !out_ready.
module gg_lattice_packer #(
  parameter int WID  = 48,
  parameter int PAD  = 32,
  parameter int IN_W = 64,
  parameter int BUF  = 256,
  parameter int NCW  = 6,
  localparam int LW  = $clog2(IN_W + 1),
  localparam int FW  = $clog2(WID + 1),
  localparam int CW  = $clog2(BUF + 1),
  localparam int TW  = $clog2(BUF * NCW + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      in_bits,
  input  logic [LW-1:0]        in_len,
  input  logic [NCW-1:0]       in_nc,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WID-1:0]       out_bits,
  output logic [PAD-1:0]       out_pad,
  output logic [WID*NCW-1:0]   out_nc,
  output logic                 out_last,
  output logic [FW-1:0]        out_fill
);

  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [BUF-1:0]       buf_q;
  logic [BUF*NCW-1:0]   tag_q;

  logic                 do_push;
  logic                 do_pop;
  logic [CW-1:0]        popped;
  logic [CW-1:0]        base;
  logic [CW-1:0]        cnt_nxt;
  logic [IN_W-1:0]      code_msk;
  logic [BUF-1:0]       code_top;
  logic [BUF-1:0]       code_sh;
  logic [TW-1:0]        tag_sh;
  logic [BUF*NCW-1:0]   tag_ins;
  logic [BUF*NCW-1:0]   tag_nxt;
  logic [BUF-1:0]       buf_nxt;

  // The window, look-ahead and tags are fixed slices of the MSB-justified buffer;
  // everything past cnt is kept zero, so no extra masking is needed here.
  assign out_bits = buf_q[BUF-1 -: WID];
  assign out_pad  = buf_q[BUF-1-WID -: PAD];
  assign out_nc   = tag_q[BUF*NCW-1 -: WID*NCW];

  // Handshake and window qualifiers from the registered fill count and state
  always_comb begin
    in_ready  = reset_n && (state_q == FILL) && (cnt_q <= CW'(BUF - IN_W));
    out_valid = (state_q == DRAIN) ? (cnt_q != '0) : (cnt_q >= CW'(WID + PAD));
    out_last  = (state_q == DRAIN) && (cnt_q != '0) && (cnt_q <= CW'(WID));
    out_fill  = (cnt_q >= CW'(WID)) ? FW'(WID) : FW'(cnt_q);
  end

  // Next buffer contents: pop first, then append the new code at the reduced count
  always_comb begin
    do_push  = in_valid && in_ready;
    do_pop   = out_valid && out_ready;
    popped   = '0;
    if (do_pop) begin
      popped = (cnt_q >= CW'(WID)) ? CW'(WID) : cnt_q;
    end
    base     = cnt_q - popped;
    // Bits above in_len are don't-care on the input, so clear them before merging.
    code_msk = in_bits & ~({IN_W{1'b1}} << in_len);
    code_top = {code_msk, {(BUF-IN_W){1'b0}}} << (LW'(IN_W) - in_len);
    code_sh  = code_top >> base;
    tag_sh   = TW'(base) * TW'(NCW);
    tag_ins  = '0;
    if (in_len != '0) begin
      tag_ins = {in_nc, {(BUF*NCW-NCW){1'b0}}} >> tag_sh;
    end
    buf_nxt  = do_pop ? (buf_q << WID) : buf_q;
    tag_nxt  = do_pop ? (tag_q << (WID*NCW)) : tag_q;
    cnt_nxt  = base;
    if (do_push) begin
      buf_nxt = buf_nxt | code_sh;
      tag_nxt = tag_nxt | tag_ins;
      cnt_nxt = base + CW'(in_len);
    end
  end

  // Buffer, fill count and FILL/DRAIN sequencing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FILL;
      cnt_q   <= '0;
      buf_q   <= '0;
      tag_q   <= '0;
    end else begin
      cnt_q <= cnt_nxt;
      buf_q <= buf_nxt;
      tag_q <= tag_nxt;
      // An empty final code on an empty buffer has nothing to drain.
      if (do_push && in_last) begin
        state_q <= (cnt_nxt == '0) ? FILL : DRAIN;
      end else if (do_pop && out_last) begin
        state_q <= FILL;
      end
    end
  end

`ifndef SYNTHESIS
  // Codes longer than IN_W cannot be placed in the buffer
  a_len_legal: assert property (@(posedge clk) disable iff (!reset_n)
                                in_valid |-> (in_len <= LW'(IN_W)));
`endif

endmodule

// File: tb/tb_gg_lattice_packer.sv
// tb_gg_lattice_packer: self-checking bench for gg_lattice_packer.
// Reference is a bit/tag queue of the whole stream; windows are read out of it by index.
// Inputs are driven on the falling edge, outputs sampled 1 time unit later.
module tb_gg_lattice_packer;
  localparam int WID  = 48;
  localparam int PAD  = 32;
  localparam int IN_W = 64;
  localparam int BUF  = 256;
  localparam int NCW  = 6;
  localparam int LW   = $clog2(IN_W + 1);
  localparam int FW   = $clog2(WID + 1);

  logic               clk = 1'b0;
  logic               reset_n;
  logic               in_valid;
  logic               in_ready;
  logic [IN_W-1:0]    in_bits;
  logic [LW-1:0]      in_len;
  logic [NCW-1:0]     in_nc;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [WID-1:0]     out_bits;
  logic [PAD-1:0]     out_pad;
  logic [WID*NCW-1:0] out_nc;
  logic               out_last;
  logic [FW-1:0]      out_fill;

  gg_lattice_packer #(.WID(WID), .PAD(PAD), .IN_W(IN_W), .BUF(BUF), .NCW(NCW)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits), .in_len(in_len),
    .in_nc(in_nc), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits), .out_pad(out_pad),
    .out_nc(out_nc), .out_last(out_last), .out_fill(out_fill)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Code list for the stream under test
  logic [IN_W-1:0] c_bits[64];
  int              c_len[64];
  logic [NCW-1:0]  c_nc[64];
  bit              c_last[64];

  // Reference stream, oldest bit first
  bit              s_bits[$];
  logic [NCW-1:0]  s_tag[$];

  typedef struct {
    logic [IN_W-1:0] bits;
    int              len;
    logic [NCW-1:0]  nc;
    logic [WID-1:0]  e_bits;
    logic [PAD-1:0]  e_pad;
    int              e_fill;
    bit              e_last;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic build_model(input int n);
    s_bits.delete();
    s_tag.delete();
    for (int i = 0; i < n; i++) begin
      for (int b = c_len[i] - 1; b >= 0; b--) begin
        s_bits.push_back(c_bits[i][b]);
        s_tag.push_back((b == c_len[i] - 1) ? c_nc[i] : '0);
      end
    end
  endtask

  task automatic exp_window(input int w, output logic [WID-1:0] eb, output logic [PAD-1:0] ep,
                            output logic [WID*NCW-1:0] en, output int ef, output bit el);
    int tot;
    tot = s_bits.size();
    eb = '0; ep = '0; en = '0;
    for (int j = 0; j < WID; j++) begin
      if (w*WID + j < tot) begin
        eb[WID-1-j] = s_bits[w*WID + j];
        en[(WID-1-j)*NCW +: NCW] = s_tag[w*WID + j];
      end
    end
    for (int j = 0; j < PAD; j++) begin
      if (w*WID + WID + j < tot) ep[PAD-1-j] = s_bits[w*WID + WID + j];
    end
    ef = tot - w*WID;
    if (ef > WID) ef = WID;
    el = (w*WID + WID >= tot);
  endtask

  // Drive codes 0..n-1 and check every cycle against the reference queue.
  // rdy_mode: 0 = always ready, 1 = ready one cycle in three, 2 = random.
  task automatic run_stream(input int n, input int rdy_mode, input string tg);
    int ci = 0, w = 0, cyc = 0, pushed = 0, popped = 0, cnt, nwin, ef;
    bit drain = 0, done = 0, exp_rdy, exp_vld, el;
    logic [WID-1:0] eb;
    logic [PAD-1:0] ep;
    logic [WID*NCW-1:0] en;
    build_model(n);
    nwin = (s_bits.size() + WID - 1) / WID;
    while (!done && cyc < 4000) begin
      @(negedge clk);
      cnt = pushed - popped;
      in_valid = (ci < n);
      if (ci < n) begin
        in_bits = c_bits[ci]; in_len = LW'(c_len[ci]); in_nc = c_nc[ci]; in_last = c_last[ci];
      end else begin
        in_last = 1'b0; in_len = '0;
      end
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      exp_rdy = !drain && (cnt + IN_W <= BUF);
      exp_vld = drain ? (cnt > 0) : (cnt >= WID + PAD);
      #1;
      chk({tg, " in_ready"}, in_ready, exp_rdy);
      chk({tg, " out_valid"}, out_valid, exp_vld);
      if (exp_vld) begin
        exp_window(w, eb, ep, en, ef, el);
        chk($sformatf("%s w%0d bits", tg, w), out_bits, eb);
        chk($sformatf("%s w%0d pad", tg, w), out_pad, ep);
        chk($sformatf("%s w%0d nc", tg, w), out_nc, en);
        chk($sformatf("%s w%0d fill", tg, w), out_fill, ef);
        chk($sformatf("%s w%0d last", tg, w), out_last, el);
        if (out_ready) begin
          popped += (cnt < WID) ? cnt : WID;
          w++;
          if (el) begin done = 1; drain = 0; end
        end
      end
      if (in_valid && exp_rdy) begin
        pushed += c_len[ci];
        if (c_last[ci]) drain = 1;
        ci++;
        if (drain && pushed == popped) begin drain = 0; done = 1; end
      end
      cyc++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s timeout: got %0d windows after %0d cycles, required %0d", tg, w, cyc, nwin);
    end
    chk({tg, " windows"}, w, nwin);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    #1;
    chk({tg, " idle out_valid"}, out_valid, 1'b0);
    chk({tg, " idle in_ready"}, in_ready, 1'b1);
  endtask

  task automatic load_mb();
    logic [NCW-1:0] nc_tab[5];
    nc_tab = '{6'd1, 6'd2, 6'd4, 6'd16, 6'd33};
    for (int i = 0; i < 26; i++) begin
      c_len[i]  = (i < 20) ? 21 : ((i == 25) ? 22 : 20);
      c_bits[i] = {$urandom, $urandom};
      c_nc[i]   = nc_tab[i % 5];
      c_last[i] = (i == 25);
    end
  endtask

  initial begin
    logic [WID*NCW-1:0] en;
    bit got;
    tbl[0] = '{64'h2ABCDEF1, 30, 6'd5, 48'hAAF37BC40000, 32'h0, 30, 1'b1};
    tbl[1] = '{64'h1, 1, 6'd1, 48'h800000000000, 32'h0, 1, 1'b1};
    tbl[2] = '{64'h123456789ABC, 48, 6'd7, 48'h123456789ABC, 32'h0, 48, 1'b1};
    tbl[3] = '{64'hFEDCBA9876543210, 64, 6'd63, 48'hFEDCBA987654, 32'h32100000, 48, 1'b0};
    tbl[4] = '{64'hFFFFFFFFFFFFFFFF, 49, 6'd9, 48'hFFFFFFFFFFFF, 32'h80000000, 48, 1'b0};
    tbl[5] = '{64'hFFFFFFFFFFFFFFF6, 5, 6'd33, 48'hB00000000000, 32'h0, 5, 1'b1};

    reset_n = 1'b0; in_valid = 1'b0; in_bits = '0; in_len = '0; in_nc = '0;
    in_last = 1'b0; out_ready = 1'b0;
    #3;
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst in_ready", in_ready, 1'b0);
    chk("rst out_last", out_last, 1'b0);
    chk("rst out_fill", out_fill, 0);
    chk("rst out_bits", out_bits, 0);
    chk("rst out_pad", out_pad, 0);
    chk("rst out_nc", out_nc, 0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    // Single-code vectors: first window contents checked against the table, then drained
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      in_valid = 1'b1; in_bits = tbl[t].bits; in_len = LW'(tbl[t].len);
      in_nc = tbl[t].nc; in_last = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      #1;
      en = '0;
      en[WID*NCW-1 -: NCW] = tbl[t].nc;
      chk($sformatf("vec%0d out_valid", t), out_valid, 1'b1);
      chk($sformatf("vec%0d in_ready", t), in_ready, 1'b0);
      chk($sformatf("vec%0d bits", t), out_bits, tbl[t].e_bits);
      chk($sformatf("vec%0d pad", t), out_pad, tbl[t].e_pad);
      chk($sformatf("vec%0d fill", t), out_fill, tbl[t].e_fill);
      chk($sformatf("vec%0d last", t), out_last, tbl[t].e_last);
      chk($sformatf("vec%0d nc", t), out_nc, en);
      got = 0;
      for (int k = 0; k < 6 && !got; k++) begin
        out_ready = 1'b1;
        if (out_valid && out_last) got = 1;
        @(negedge clk);
        #1;
      end
      out_ready = 1'b0;
      if (!got) begin
        checks++; errors++;
        $display("FAIL vec%0d drain: got no final window, required one", t);
      end
      chk($sformatf("vec%0d idle out_valid", t), out_valid, 1'b0);
      chk($sformatf("vec%0d idle in_ready", t), in_ready, 1'b1);
    end

    // Full macroblock stream: 542 bits -> 12 windows, then the same with 1-of-3 ready
    load_mb();
    run_stream(26, 0, "mb");
    run_stream(26, 1, "mb_bp");

    // Single code of 30 bits through the generic path
    c_len[0] = 30; c_bits[0] = 64'h2ABCDEF1; c_nc[0] = 6'd12; c_last[0] = 1'b1;
    run_stream(1, 0, "single");

    // Maximum-length codes, then an empty final code on an empty buffer
    for (int i = 0; i < 4; i++) begin
      c_len[i] = 64; c_bits[i] = {$urandom, $urandom}; c_nc[i] = 6'(i + 3); c_last[i] = (i == 3);
    end
    run_stream(4, 1, "len64");
    c_len[0] = 0; c_bits[0] = {$urandom, $urandom}; c_nc[0] = 6'd5; c_last[0] = 1'b1;
    run_stream(1, 0, "len0");

    // Randomized streams with random back-pressure
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 30; i++) begin
        c_len[i]  = $urandom_range(0, IN_W);
        c_bits[i] = {$urandom, $urandom};
        c_nc[i]   = 6'($urandom_range(0, 63));
        c_last[i] = (i == 29);
      end
      run_stream(30, 2, $sformatf("rnd%0d", r));
    end

    // Reset with 100 bits buffered discards everything
    @(negedge clk);
    in_valid = 1'b1; in_bits = {$urandom, $urandom}; in_len = LW'(50); in_nc = 6'd3;
    in_last = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre-rst out_valid", out_valid, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mid-rst out_valid", out_valid, 1'b0);
    chk("mid-rst in_ready", in_ready, 1'b0);
    chk("mid-rst out_fill", out_fill, 0);
    chk("mid-rst out_bits", out_bits, 0);
    @(negedge clk);
    reset_n = 1'b1;
    c_len[0] = 1; c_bits[0] = 64'h1; c_nc[0] = 6'd2; c_last[0] = 1'b1;
    run_stream(1, 0, "post-rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
